uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
- Serial receive front-end for main_module's command path: samples the rtx pad line, deframes 8N1 UART characters, and buffers them in a small first-word-fall-through FIFO.
- Presents a valid/ready byte stream to the command decoder.
- Sits between the rtx IO pad and main_module; raises per-character error pulses for status logic.

Parameters:
- DATA_WIDTH, 8, bits per character, LSB first.
- BAUD_RATE, 115200, line bit rate.
- CLOCK_SPEED, 100000000, clk frequency in Hz.
- FIFO_DEPTH, 4, buffered characters; power of 2, at least 2.
- Derived: CLKS_PER_BIT = CLOCK_SPEED/BAUD_RATE (integer division), HALF_BIT = CLKS_PER_BIT/2.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset.
- rtx  input  1  serial line from pad; idle high.
- data_o  output  DATA_WIDTH  FIFO head character.
- valid_o  output  1  FIFO non-empty.
- ready_i  input  1  consumer accepts data_o this cycle.
- level_o  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- busy_o  output  1  receiver is not in IDLE.
- frame_err_o  output  1  one-cycle pulse: stop bit sampled low.
- overrun_o  output  1  one-cycle pulse: good character dropped because FIFO full.

Behaviour:
- Reset (rst=0, async), all values forced:
  - 2-FF synchronizer = 1; state = IDLE; bit counter, baud counter, shift register = 0.
  - FIFO pointers and count = 0; data_o = 0; valid_o = 0; level_o = 0; busy_o = 0; frame_err_o = 0; overrun_o = 0.
- Reset mid-character discards the partial character and all FIFO contents.
- Input: rtx passes through a 2-FF synchronizer (rx_s). All decisions use rx_s only.
- State machine (busy_o = state != IDLE):
  - IDLE: rx_s==0 -> START, baud counter = 0.
  - START: at count HALF_BIT-1:
    - rx_s==0 -> DATA, counter = 0, bit index = 0.
    - rx_s==1 -> IDLE (glitch rejected, no pulse).
  - DATA: at count CLKS_PER_BIT-1, shift rx_s in LSB-first and clear the counter. After DATA_WIDTH bits -> STOP.
  - STOP: at count CLKS_PER_BIT-1, sample rx_s:
    - rx_s==1, FIFO not full: push character -> IDLE.
    - rx_s==1, FIFO full and no pop this cycle: drop character, overrun_o=1 for 1 cycle -> IDLE.
    - rx_s==0: discard character, frame_err_o=1 for 1 cycle -> BREAK.
  - BREAK: wait for rx_s==1 -> IDLE. A line held low (break) yields exactly one frame_err_o pulse.
- Sampling points: mid-bit, i.e. HALF_BIT + k*CLKS_PER_BIT clocks after the synchronized falling edge.
- FIFO (first-word-fall-through):
  - data_o = mem[rd_ptr]; valid_o = (count != 0).
  - Pop when valid_o && ready_i. ready_i while empty has no effect.
  - Push and pop in the same cycle: count unchanged, both take effect. Applies when full, so no overrun, and when empty.
  - Pointers wrap modulo FIFO_DEPTH.
  - level_o = count, range 0..FIFO_DEPTH.
- Latency: a pushed character appears on data_o/valid_o the cycle after the STOP sample.
- data_o is held stable while valid_o=1 and ready_i=0.
- frame_err_o and overrun_o are never asserted in the same cycle, and are never asserted outside STOP.

Test Plan (CLOCK_SPEED=1000000, BAUD_RATE=100000, so CLKS_PER_BIT=10, HALF_BIT=5; FIFO_DEPTH=4):
- Reset hold: rst=0 with rtx toggling -> all outputs 0, busy_o=0. Release -> outputs stay 0 while rtx=1.
- Single char: send 0xA5 (8N1), ready_i=0 -> data_o=0xA5, valid_o=1, level_o=1 starting the cycle after the stop sample; no error pulses. Then ready_i=1 for one cycle -> valid_o=0, level_o=0.
- Glitch: rtx low for 3 clocks, then high -> busy_o returns to 0 by start sample, no push, no pulses.
- Frame error: send 0x3C with stop bit 0, then hold rtx low 50 clocks -> exactly one frame_err_o pulse, level_o unchanged, busy_o=1 until rtx high. Follow-up 0x11 is received correctly.
- Overrun: ready_i=0, send 0x01,0x02,0x03,0x04,0x05 -> level_o=4, one overrun_o pulse on the fifth. Draining yields 0x01..0x04 in order.
- Full with simultaneous pop: FIFO full (0x01..0x04), ready_i=1 held during the stop sample of 0x06 -> no overrun_o, level_o stays 4. Final drain order is 0x02,0x03,0x04,0x06 (wrap-around exercised).

Source files
------------

// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: byte stream from the UART receive FIFO to its consumer
interface uart_rx_fifo_if #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
);
  logic [DATA_WIDTH-1:0] data_o;
  logic valid_o;
  logic ready_i;
  logic [$clog2(FIFO_DEPTH):0] level_o;
  modport master (output data_o, valid_o, level_o, input ready_i);
  modport slave (input data_o, valid_o, level_o, output ready_i);
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver feeding a first-word-fall-through FIFO
module uart_rx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int BAUD_RATE = 115200,
  parameter int CLOCK_SPEED = 100000000,
  parameter int FIFO_DEPTH = 4
) (
  input logic clk,
  input logic rst,
  input logic rtx,
  uart_rx_fifo_if.master bus,
  output logic busy_o,
  output logic frame_err_o,
  output logic overrun_o
);
  localparam int CLKS_PER_BIT = CLOCK_SPEED / BAUD_RATE;
  localparam int HALF_BIT = CLKS_PER_BIT / 2;
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam int IW = $clog2(DATA_WIDTH + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA = 3'd2;
  localparam logic [2:0] STOP = 3'd3;
  localparam logic [2:0] BREAK = 3'd4;
  logic rx_m, rx_s;
  logic [2:0] state;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic [DATA_WIDTH-1:0] shreg;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic tick_bit, stop_hit, full, pop, push;
  assign tick_bit = cnt == CW'(CLKS_PER_BIT - 1);
  assign stop_hit = state == STOP && tick_bit;
  assign full = count == (AW + 1)'(FIFO_DEPTH);
  assign pop = bus.valid_o && bus.ready_i;
  // a full FIFO still accepts the character when the head leaves in the same cycle
  assign push = stop_hit && rx_s && (!full || pop);
  assign overrun_o = stop_hit && rx_s && full && !pop;
  assign frame_err_o = stop_hit && !rx_s;
  assign busy_o = state != IDLE;
  assign bus.valid_o = count != '0;
  assign bus.level_o = count;
  assign bus.data_o = mem[rd_ptr];
  // two-stage synchronizer for the asynchronous pad line
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rtx;
      rx_s <= rx_m;
    end
  // deframer: half-bit start qualification, then mid-bit sampling of data and stop
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      shreg <= '0;
    end else
      case (state)
        IDLE: if (!rx_s) begin
          state <= START;
          cnt <= '0;
        end
        START: if (cnt == CW'(HALF_BIT - 1)) begin
          state <= rx_s ? IDLE : DATA;
          cnt <= '0;
          idx <= '0;
        end else cnt <= cnt + 1'b1;
        DATA: if (tick_bit) begin
          shreg <= {rx_s, shreg[DATA_WIDTH-1:1]};
          cnt <= '0;
          idx <= idx + 1'b1;
          if (idx == IW'(DATA_WIDTH - 1)) state <= STOP;
        end else cnt <= cnt + 1'b1;
        STOP: if (tick_bit) begin
          state <= rx_s ? IDLE : BREAK;
          cnt <= '0;
        end else cnt <= cnt + 1'b1;
        BREAK: if (rx_s) state <= IDLE;
        default: state <= IDLE;
      endcase
  // FIFO storage, power-of-two pointers wrap naturally
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= shreg;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: randomized scoreboard bench for the UART receive FIFO
module tb_uart_rx_fifo;
  localparam int DW = 8;
  localparam int DEPTH = 4;
  localparam int CPB = 10;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rtx = 1'b1;
  logic busy_o, frame_err_o, overrun_o;
  int n_checks = 0;
  int n_fail = 0;
  int fe_seen = 0;
  int ov_seen = 0;
  int fe_exp = 0;
  int ov_exp = 0;
  logic [DW-1:0] exp_q[$];
  bit hold_prev = 0;
  logic [DW-1:0] data_prev;
  bit done;
  uart_rx_fifo_if #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) bus ();
  uart_rx_fifo #(
    .DATA_WIDTH(DW), .BAUD_RATE(100000), .CLOCK_SPEED(1000000), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .rtx(rtx), .bus(bus),
    .busy_o(busy_o), .frame_err_o(frame_err_o), .overrun_o(overrun_o)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  // the model: a good character is kept only if the FIFO (after any pop at the sample) has room
  task automatic send(input logic [DW-1:0] d, input logic stop, input bit pop_at_stop = 0);
    rtx = 1'b0;
    tick(CPB);
    for (int i = 0; i < DW; i++) begin
      rtx = d[i];
      tick(CPB);
    end
    rtx = stop;
    tick(CPB - 3);
    if (pop_at_stop) bus.ready_i = 1'b1;
    tick(1);
    if (pop_at_stop) bus.ready_i = 1'b0;
    if (!stop) fe_exp++;
    else if (exp_q.size() < DEPTH) exp_q.push_back(d);
    else ov_exp++;
    tick(2);
  endtask
  task automatic drain();
    bus.ready_i = 1'b1;
    for (int i = 0; i < 100 && bus.level_o != 0; i++) tick(1);
    bus.ready_i = 1'b0;
    check("drain level", bus.level_o, 0);
  endtask
  // monitor: pops the scoreboard on every accepted byte, tracks pulses and occupancy
  always @(negedge clk)
    if (rst) begin
      check("level", bus.level_o, exp_q.size());
      check("valid", bus.valid_o, exp_q.size() != 0);
      if (hold_prev) check("data hold", bus.data_o, data_prev);
      if (frame_err_o) fe_seen++;
      if (overrun_o) ov_seen++;
      if (frame_err_o || overrun_o) begin
        check("pulse exclusive", frame_err_o && overrun_o, 0);
        check("pulse while busy", busy_o, 1);
      end
      if (bus.valid_o && bus.ready_i) begin
        if (exp_q.size() == 0) check("unexpected pop", 1, 0);
        else check("pop data", bus.data_o, exp_q.pop_front());
      end
      hold_prev = bus.valid_o && !bus.ready_i;
      data_prev = bus.data_o;
    end else hold_prev = 0;
  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    bus.ready_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rtx = i[0];
      tick(1);
    end
    check("rst valid", bus.valid_o, 0);
    check("rst level", bus.level_o, 0);
    check("rst data", bus.data_o, 0);
    check("rst busy", busy_o, 0);
    check("rst frame_err", frame_err_o, 0);
    check("rst overrun", overrun_o, 0);
    rtx = 1'b1;
    tick(2);
    rst = 1'b1;
    tick(20);
    check("idle valid", bus.valid_o, 0);
    check("idle busy", busy_o, 0);
    check("idle data", bus.data_o, 0);
    send(8'hA5, 1'b1);
    check("single data", bus.data_o, 8'hA5);
    check("single valid", bus.valid_o, 1);
    check("single level", bus.level_o, 1);
    check("single no frame_err", fe_seen, 0);
    check("single no overrun", ov_seen, 0);
    bus.ready_i = 1'b1;
    tick(1);
    bus.ready_i = 1'b0;
    check("single popped valid", bus.valid_o, 0);
    check("single popped level", bus.level_o, 0);
    rtx = 1'b0;
    tick(3);
    check("glitch busy", busy_o, 1);
    rtx = 1'b1;
    tick(10);
    check("glitch idle", busy_o, 0);
    check("glitch level", bus.level_o, 0);
    check("glitch no pulse", fe_seen + ov_seen, 0);
    send(8'h3C, 1'b0);
    tick(48);
    check("break busy", busy_o, 1);
    check("break level", bus.level_o, 0);
    check("break one pulse", fe_seen, 1);
    rtx = 1'b1;
    tick(5);
    check("break released", busy_o, 0);
    send(8'h11, 1'b1);
    check("after break data", bus.data_o, 8'h11);
    check("after break pulses", fe_seen, fe_exp);
    drain();
    for (int v = 1; v <= 5; v++) send(DW'(v), 1'b1);
    check("overrun level", bus.level_o, 4);
    check("overrun pulse", ov_seen, 1);
    check("overrun model", ov_seen, ov_exp);
    drain();
    for (int v = 1; v <= 4; v++) send(DW'(v), 1'b1);
    send(8'h06, 1'b1, 1);
    check("full pop no overrun", ov_seen, 1);
    check("full pop level", bus.level_o, 4);
    check("full pop head", bus.data_o, 8'h02);
    drain();
    send(8'h55, 1'b1);
    send(8'h66, 1'b1);
    rtx = 1'b0;
    tick(30);
    rst = 1'b0;
    exp_q.delete();
    tick(2);
    check("midchar rst level", bus.level_o, 0);
    check("midchar rst valid", bus.valid_o, 0);
    check("midchar rst busy", busy_o, 0);
    check("midchar rst data", bus.data_o, 0);
    rtx = 1'b1;
    tick(2);
    rst = 1'b1;
    tick(5);
    send(8'h77, 1'b1);
    check("post rst data", bus.data_o, 8'h77);
    drain();
    repeat (30) begin
      done = 0;
      fork
        begin
          logic [DW-1:0] r;
          bit bad;
          int n;
          n = $urandom_range(1, DEPTH);
          for (int j = 0; j < n; j++) begin
            r = DW'($urandom);
            bad = $urandom_range(0, 7) == 0;
            send(r, !bad);
            if (bad) begin
              tick($urandom_range(0, 20));
              rtx = 1'b1;
              tick(4);
            end
            tick($urandom_range(0, 5));
          end
          done = 1;
        end
        begin
          while (!done) begin
            bus.ready_i = 1'($urandom_range(0, 1));
            tick(1);
          end
        end
      join
      drain();
    end
    check("final frame_err count", fe_seen, fe_exp);
    check("final overrun count", ov_seen, ov_exp);
    check("final scoreboard empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
